// File: rtl/sal_rd_ctrl_if.sv
// SAL read-return bus: scheduler grant/credit, DFI read data and AXI R channel.
// ovf_err_o exists only when SAL_RD_OVF_CHECK_EN is defined.
interface sal_rd_ctrl_if #(parameter int ID_WIDTH = 4);
  logic                rd_gnt_i;
  logic [ID_WIDTH-1:0] rd_id_i;
  logic                rd_credit_o;
  logic [3:0]          dfi_rden_lat_i;
  logic                dfi_rddata_en_o;
  logic [127:0]        dfi_rddata_i;
  logic                dfi_rddata_valid_i;
  logic [ID_WIDTH-1:0] rid_o;
  logic [127:0]        rdata_o;
  logic [1:0]          rresp_o;
  logic                rlast_o;
  logic                rvalid_o;
  logic                rready_i;
`ifdef SAL_RD_OVF_CHECK_EN
  logic                ovf_err_o;
`endif

  modport slave (
    input  rd_gnt_i, rd_id_i, dfi_rden_lat_i, dfi_rddata_i, dfi_rddata_valid_i, rready_i,
    output rd_credit_o, dfi_rddata_en_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
`ifdef SAL_RD_OVF_CHECK_EN
    , ovf_err_o
`endif
  );

  modport master (
    output rd_gnt_i, rd_id_i, dfi_rden_lat_i, dfi_rddata_i, dfi_rddata_valid_i, rready_i,
    input  rd_credit_o, dfi_rddata_en_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
`ifdef SAL_RD_OVF_CHECK_EN
    , ovf_err_o
`endif
  );
endinterface

// File: rtl/sal_rd_ctrl.sv
// SAL DDR read-data return path: rddata_en timing, credit-guarded read FIFO, 2-beat AXI R replay.
// Optional overflow/underflow checking with SLVERR tagging when SAL_RD_OVF_CHECK_EN is defined.
module sal_rd_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wptr, rptr;
  logic         full, empty, do_push, do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(1 << AW));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only taken when the same cycle frees a slot.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module sal_rd_ctrl #(
  parameter int DEPTH_LG2 = 3,
  parameter int ID_WIDTH  = 4
) (
  input logic          clk,
  input logic          rst,
  sal_rd_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam int CW    = DEPTH_LG2 + 1;

  logic [15:0]          vld_pipe;
  logic [CW-1:0]        inflight, occ;
  logic [DEPTH_LG2-1:0] id_cnt;
  logic [127:0]         d_head;
  logic [ID_WIDTH-1:0]  id_head;
  logic                 d_empty, d_full, id_empty, id_full;
  logic                 beat, r_pop, last_pop, id_push, dec;
  logic [CW+1:0]        free;

  // Each grant seeds two adjacent enable bits; the latency just picks the tap.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[14:0], 1'b0} | (bus.rd_gnt_i ? 16'h3 : 16'h0);
  end
  assign bus.dfi_rddata_en_o = vld_pipe[bus.dfi_rden_lat_i];

  assign d_empty  = (occ == '0);
  assign d_full   = (occ == CW'(DEPTH));
  assign id_empty = (id_cnt == '0);
  assign id_full  = (id_cnt == DEPTH_LG2'(DEPTH / 2));
  assign r_pop    = ~d_empty & bus.rready_i;
  assign last_pop = r_pop & beat;
  assign id_push  = bus.rd_gnt_i & ~id_full;

  sal_rd_fifo #(.W(128), .AW(DEPTH_LG2)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.dfi_rddata_valid_i),
    .wdata (bus.dfi_rddata_i),
    .pop   (r_pop),
    .head  (d_head),
    .count (occ)
  );

  sal_rd_fifo #(.W(ID_WIDTH), .AW(DEPTH_LG2-1)) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (id_push),
    .wdata (bus.rd_id_i),
    .pop   (last_pop),
    .head  (id_head),
    .count (id_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst)        beat <= 1'b0;
    else if (r_pop) beat <= ~beat;
  end

  // A beat with nothing in flight is spurious and must not wrap the counter.
  assign dec = bus.dfi_rddata_valid_i & (inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight + (bus.rd_gnt_i ? CW'(2) : CW'(0)) - (dec ? CW'(1) : CW'(0));
  end

  // Signed headroom so an illegal over-grant reads as no credit, not a wrap.
  always_comb begin
    free            = (CW+2)'(DEPTH) - (CW+2)'(occ) - (CW+2)'(inflight);
    bus.rd_credit_o = ~free[CW+1] & (free[CW:0] >= (CW+1)'(2));
  end

  assign bus.rvalid_o = ~d_empty;
  assign bus.rdata_o  = d_empty  ? '0 : d_head;
  assign bus.rid_o    = id_empty ? '0 : id_head;
  assign bus.rlast_o  = ~d_empty & beat;

`ifdef SAL_RD_OVF_CHECK_EN
  logic ovf;

  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else if (bus.dfi_rddata_valid_i & ((d_full & ~r_pop) | (inflight == '0)))
      ovf <= 1'b1;
  end

  assign bus.ovf_err_o = ovf;
  assign bus.rresp_o   = (~d_empty & ovf) ? 2'b10 : 2'b00;
`else
  assign bus.rresp_o   = 2'b00;
`endif
endmodule

// File: tb/tb_sal_rd_ctrl.sv
// Scoreboard bench for sal_rd_ctrl: DFI responder returns data 2 cycles after rddata_en,
// R monitor pops expected beats/IDs. Overflow scenario runs when SAL_RD_OVF_CHECK_EN is defined.
module tb_sal_rd_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sal_rd_ctrl_if #(.ID_WIDTH(4)) bus();

  sal_rd_ctrl #(.DEPTH_LG2(3), .ID_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_chk = 0;
  int           n_fail = 0;
  int           hs_cnt = 0;
  logic [127:0] data_q[$];
  logic [3:0]   id_q[$];
  logic         rsp_en = 1'b0;
  logic         mon_en = 1'b0;
  logic         rsp_valid, man_valid;
  logic [127:0] rsp_data, man_data, dcnt;
  logic [1:0]   exp_resp;

  assign bus.dfi_rddata_valid_i = rsp_valid | man_valid;
  assign bus.dfi_rddata_i       = man_valid ? man_data : rsp_data;

  // DFI model: data follows rddata_en by two cycles.
  initial begin
    logic [1:0] p;
    p = 2'b00; rsp_valid = 1'b0; rsp_data = '0;
    forever begin
      @(negedge clk);
      if (rst || !rsp_en) begin
        p = 2'b00; rsp_valid = 1'b0;
      end else begin
        rsp_valid = p[1];
        if (p[1]) begin
          rsp_data = dcnt; data_q.push_back(dcnt); dcnt = dcnt + 1;
        end
        p = {p[0], bus.dfi_rddata_en_o};
      end
    end
  end

  // R monitor: checks each handshake against the scoreboard and stall stability.
  initial begin
    logic stall, beat, pl;
    logic [127:0] pd;
    logic [3:0] pid;
    logic [1:0] pr;
    stall = 0; beat = 0; pl = 0; pd = '0; pid = '0; pr = '0;
    forever begin
      @(negedge clk); #1;
      if (rst || !mon_en) begin
        stall = 0; beat = 0;
      end else begin
        if (stall) begin
          n_chk++;
          if ({bus.rvalid_o, bus.rdata_o, bus.rid_o, bus.rlast_o, bus.rresp_o} !== {1'b1, pd, pid, pl, pr}) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b d=%h id=%h last=%b, held d=%h id=%h last=%b", bus.rvalid_o, bus.rdata_o, bus.rid_o, bus.rlast_o, pd, pid, pl);
          end
        end
        if (bus.rvalid_o && bus.rready_i) begin
          hs_cnt++;
          n_chk++;
          if (data_q.size() == 0 || id_q.size() == 0) begin
            n_fail++;
            $display("FAIL r_unexpected: beat d=%h id=%h with empty scoreboard", bus.rdata_o, bus.rid_o);
          end else begin
            if (bus.rdata_o !== data_q[0] || bus.rid_o !== id_q[0] || bus.rlast_o !== beat || bus.rresp_o !== exp_resp) begin
              n_fail++;
              $display("FAIL r_beat: got d=%h id=%h last=%b resp=%b, want d=%h id=%h last=%b resp=%b", bus.rdata_o, bus.rid_o, bus.rlast_o, bus.rresp_o, data_q[0], id_q[0], beat, exp_resp);
            end
            void'(data_q.pop_front());
            if (beat) void'(id_q.pop_front());
            beat = ~beat;
          end
        end
        stall = bus.rvalid_o && !bus.rready_i;
        pd = bus.rdata_o; pid = bus.rid_o; pl = bus.rlast_o; pr = bus.rresp_o;
      end
    end
  end

  task automatic do_grant(input logic [3:0] id);
    @(negedge clk);
    bus.rd_gnt_i = 1'b1; bus.rd_id_i = id; id_q.push_back(id);
    @(negedge clk);
    bus.rd_gnt_i = 1'b0;
  endtask

  task automatic man_beat(input bit keep);
    @(negedge clk);
    man_valid = 1'b1; man_data = dcnt;
    if (keep) data_q.push_back(dcnt);
    dcnt = dcnt + 1;
  endtask

  task automatic wait_drain(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rnd) bus.rready_i = 1'($urandom_range(0, 1));
      #2;
      if (id_q.size() == 0 && data_q.size() == 0 && !bus.rvalid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if (bus.rvalid_o !== 1'b0 || bus.rlast_o !== 1'b0 || bus.dfi_rddata_en_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: rvalid=%b rlast=%b en=%b, want 0 0 0", bus.rvalid_o, bus.rlast_o, bus.dfi_rddata_en_o);
    end
    n_chk++;
    if (bus.rd_credit_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_credit: got %b want 1", bus.rd_credit_o);
    end
    n_chk++;
    if (bus.rid_o !== 4'h0 || bus.rdata_o !== 128'h0 || bus.rresp_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_data: rid=%h rdata=%h rresp=%b, want 0", bus.rid_o, bus.rdata_o, bus.rresp_o);
    end
`ifdef SAL_RD_OVF_CHECK_EN
    n_chk++;
    if (bus.ovf_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf_err_o);
    end
`endif
    @(negedge clk);
    rst = 1'b0; mon_en = 1'b1;
  endtask

  task automatic test_single;
    bit ok;
    int start;
    rsp_en = 1'b1; bus.rready_i = 1'b1; dcnt = 128'hA; start = hs_cnt;
    @(negedge clk);
    bus.rd_gnt_i = 1'b1; bus.rd_id_i = 4'h5; id_q.push_back(4'h5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.rd_gnt_i = 1'b0;
      #2;
      n_chk++;
      if (bus.dfi_rddata_en_o !== (k == 3 || k == 4)) begin
        n_fail++; $display("FAIL single_en t+%0d: got %b want %b", k, bus.dfi_rddata_en_o, (k == 3 || k == 4));
      end
    end
    wait_drain(40, 1'b0, ok);
    n_chk++;
    if (!ok || hs_cnt - start != 2) begin
      n_fail++; $display("FAIL single_drain: done=%b beats=%0d want done=1 beats=2", ok, hs_cnt - start);
    end
  endtask

  task automatic test_credit;
    bit ok;
    rsp_en = 1'b1; bus.rready_i = 1'b0;
    for (int g = 0; g < 4; g++) begin
      do_grant(4'(g + 8));
      #2;
      n_chk++;
      if (bus.rd_credit_o !== (g < 3)) begin
        n_fail++; $display("FAIL credit_grant%0d: got %b want %b", g, bus.rd_credit_o, (g < 3));
      end
    end
    repeat (12) @(negedge clk);
    #2;
    n_chk++;
    if (bus.rd_credit_o !== 1'b0 || bus.rvalid_o !== 1'b1) begin
      n_fail++; $display("FAIL credit_full: credit=%b rvalid=%b want 0 1", bus.rd_credit_o, bus.rvalid_o);
    end
    @(negedge clk); bus.rready_i = 1'b1; #2;
    n_chk++;
    if (bus.rd_credit_o !== 1'b0) begin
      n_fail++; $display("FAIL credit_pop0: got %b want 0", bus.rd_credit_o);
    end
    @(negedge clk); #2;
    n_chk++;
    if (bus.rd_credit_o !== 1'b0) begin
      n_fail++; $display("FAIL credit_pop1: got %b want 0", bus.rd_credit_o);
    end
    @(negedge clk); #2;
    n_chk++;
    if (bus.rd_credit_o !== 1'b1) begin
      n_fail++; $display("FAIL credit_pop2: got %b want 1", bus.rd_credit_o);
    end
    wait_drain(60, 1'b0, ok);
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL credit_drain: timeout, %0d beats left", data_q.size());
    end
    bus.rready_i = 1'b0;
  endtask

  task automatic test_order;
    bit ok;
    int start;
    rsp_en = 1'b1; bus.rready_i = 1'b0; start = hs_cnt;
    do_grant(4'h1); do_grant(4'h2); do_grant(4'h3);
    wait_drain(400, 1'b1, ok);
    n_chk++;
    if (!ok || hs_cnt - start != 6) begin
      n_fail++; $display("FAIL order_drain: done=%b beats=%0d want done=1 beats=6", ok, hs_cnt - start);
    end
    @(negedge clk); bus.rready_i = 1'b0;
  endtask

  task automatic test_same_cycle;
    bit ok;
    rsp_en = 1'b0; bus.rready_i = 1'b0;
    do_grant(4'h7);
    man_beat(1'b1);
    man_beat(1'b1);
    bus.rd_gnt_i = 1'b1; bus.rd_id_i = 4'h8; id_q.push_back(4'h8);
    @(negedge clk);
    man_valid = 1'b0; bus.rd_gnt_i = 1'b0;
    #2;
    n_chk++;
    if (bus.rd_credit_o !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_free4: got %b want 1", bus.rd_credit_o);
    end
    do_grant(4'h9); #2;
    n_chk++;
    if (bus.rd_credit_o !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_free2: got %b want 1", bus.rd_credit_o);
    end
    do_grant(4'hA); #2;
    n_chk++;
    if (bus.rd_credit_o !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_free0: got %b want 0", bus.rd_credit_o);
    end
    for (int i = 0; i < 6; i++) man_beat(1'b1);
    @(negedge clk); man_valid = 1'b0;
    bus.rready_i = 1'b1;
    wait_drain(60, 1'b0, ok);
    n_chk++;
    if (!ok || bus.rd_credit_o !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_drain: done=%b credit=%b want 1 1", ok, bus.rd_credit_o);
    end
    bus.rready_i = 1'b0;
  endtask

`ifdef SAL_RD_OVF_CHECK_EN
  task automatic test_ovf;
    bit ok;
    rsp_en = 1'b0; bus.rready_i = 1'b0;
    for (int g = 1; g <= 4; g++) do_grant(4'(g));
    for (int i = 0; i < 8; i++) man_beat(1'b1);
    man_beat(1'b0);
    #2;
    n_chk++;
    if (bus.ovf_err_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before: got %b want 0", bus.ovf_err_o);
    end
    @(negedge clk); man_valid = 1'b0; #2;
    n_chk++;
    if (bus.ovf_err_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b want 1", bus.ovf_err_o);
    end
    exp_resp = 2'b10; bus.rready_i = 1'b1;
    wait_drain(60, 1'b0, ok);
    n_chk++;
    if (!ok || bus.ovf_err_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drain: done=%b ovf=%b want 1 1", ok, bus.ovf_err_o);
    end
    @(negedge clk); rst = 1'b1; bus.rready_i = 1'b0;
    @(negedge clk); rst = 1'b0; #2;
    n_chk++;
    if (bus.ovf_err_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 0", bus.ovf_err_o);
    end
    exp_resp = 2'b00;
  endtask
`endif

  task automatic test_reset_mid;
    bit seen;
    int start;
    rsp_en = 1'b1; bus.rready_i = 1'b1; start = hs_cnt; seen = 1'b0;
    do_grant(4'hC);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (hs_cnt > start) begin seen = 1'b1; break; end
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL reset_mid_beat1: no first beat, got %0d beats want 1", hs_cnt - start);
    end
    @(negedge clk);
    rst = 1'b1; mon_en = 1'b0; bus.rready_i = 1'b0;
    data_q.delete(); id_q.delete();
    @(negedge clk);
    rst = 1'b0; #2;
    n_chk++;
    if (bus.rvalid_o !== 1'b0 || bus.rd_credit_o !== 1'b1 || bus.dfi_rddata_en_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: rvalid=%b credit=%b en=%b want 0 1 0", bus.rvalid_o, bus.rd_credit_o, bus.dfi_rddata_en_o);
    end
    mon_en = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    n_chk++;
    if (bus.rvalid_o !== 1'b0 || bus.rd_credit_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_idle: rvalid=%b credit=%b want 0 1", bus.rvalid_o, bus.rd_credit_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_gnt_i = 1'b0; bus.rd_id_i = '0; bus.dfi_rden_lat_i = 4'd3; bus.rready_i = 1'b0;
    man_valid = 1'b0; man_data = '0; exp_resp = 2'b00; dcnt = '0;
    test_reset;
    test_single;
    test_credit;
    test_order;
    test_same_cycle;
`ifdef SAL_RD_OVF_CHECK_EN
    test_ovf;
`endif
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
